// File: rtl/traffic_light_ctrl.sv
// Multi-direction traffic light controller: round-robin green service with
// demand-driven green extension, pedestrian walk phase and emergency override.
module traffic_light_ctrl #(
  parameter int N_DIR     = 4,
  parameter int GREEN_MIN = 4,
  parameter int GREEN_MAX = 10,
  parameter int YELLOW_T  = 2,
  parameter int ALLRED_T  = 1,
  parameter int WALK_T    = 3
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [N_DIR-1:0]           req,
  input  logic                       ped_req,
  input  logic                       emerg,
  output logic [2*N_DIR-1:0]         lights,
  output logic                       walk,
  output logic [2:0]                 state_o,
  output logic [$clog2(N_DIR)-1:0]   cur_dir
);

  localparam int DIR_W   = $clog2(N_DIR);
  localparam int MAX_GY  = (GREEN_MAX > YELLOW_T) ? GREEN_MAX : YELLOW_T;
  localparam int MAX_AW  = (ALLRED_T > WALK_T) ? ALLRED_T : WALK_T;
  localparam int CNT_TOP = (MAX_GY > MAX_AW) ? MAX_GY : MAX_AW;
  localparam int CNT_W   = $clog2(CNT_TOP + 1);

  localparam logic [CNT_W-1:0] GMIN_C  = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] GMAX_C  = CNT_W'(GREEN_MAX - 1);
  localparam logic [CNT_W-1:0] YEL_C   = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] AR_C    = CNT_W'(ALLRED_T - 1);
  localparam logic [CNT_W-1:0] WALK_C  = CNT_W'(WALK_T - 1);
  localparam logic [CNT_W-1:0] CNT_SAT = '1;

  localparam logic [1:0] LAMP_RED    = 2'b00;
  localparam logic [1:0] LAMP_YELLOW = 2'b01;
  localparam logic [1:0] LAMP_GREEN  = 2'b10;

  typedef enum logic [2:0] {
    ST_GREEN  = 3'd0,
    ST_YELLOW = 3'd1,
    ST_ALLRED = 3'd2,
    ST_PED    = 3'd3,
    ST_EMERG  = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [DIR_W-1:0] dir_nxt;
  logic             ped_pend;
  logic [N_DIR-1:0] dir_mask;
  logic             other_req;

  // First requesting direction after cur, wrapping, cur excluded; cur+1 if none.
  function automatic logic [DIR_W-1:0] rr_next(input logic [DIR_W-1:0] cur,
                                               input logic [N_DIR-1:0] r);
    logic [DIR_W-1:0] nxt;
    logic [DIR_W-1:0] idx;
    nxt = DIR_W'((int'(cur) + 1) % N_DIR);
    for (int k = N_DIR - 1; k >= 1; k--) begin
      idx = DIR_W'((int'(cur) + k) % N_DIR);
      if (r[idx]) nxt = idx;
    end
    return nxt;
  endfunction

  always_comb begin
    dir_mask          = '0;
    dir_mask[cur_dir] = 1'b1;
  end

  assign other_req = |(req & ~dir_mask);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= ST_GREEN;
      cnt      <= '0;
      cur_dir  <= '0;
      ped_pend <= 1'b0;
    end else begin
      state   <= state_nxt;
      cur_dir <= dir_nxt;
      if (state_nxt != state) cnt <= '0;
      else if (cnt != CNT_SAT) cnt <= cnt + 1'b1;
      // A new button press outside PED wins over the clear on PED entry.
      if (state != ST_PED && ped_req) ped_pend <= 1'b1;
      else if (state_nxt == ST_PED)   ped_pend <= 1'b0;
    end
  end

  // NOTE: every combinational output gets a default first so no path
  // through the case leaves it unassigned (which would infer a latch).
  always_comb begin
    state_nxt = state;
    dir_nxt   = cur_dir;
    if (emerg) begin
      state_nxt = ST_EMERG;
    end else begin
      case (state)
        ST_GREEN: begin
          if ((cnt >= GMIN_C && (other_req || ped_pend)) || cnt == GMAX_C)
            state_nxt = ST_YELLOW;
        end
        ST_YELLOW: begin
          if (cnt == YEL_C) state_nxt = ST_ALLRED;
        end
        ST_ALLRED: begin
          if (cnt == AR_C) begin
            if (ped_pend) begin
              state_nxt = ST_PED;
            end else begin
              state_nxt = ST_GREEN;
              dir_nxt   = rr_next(cur_dir, req);
            end
          end
        end
        ST_PED: begin
          if (cnt == WALK_C) begin
            state_nxt = ST_GREEN;
            dir_nxt   = rr_next(cur_dir, req);
          end
        end
        ST_EMERG: state_nxt = ST_ALLRED;
        default:  state_nxt = ST_ALLRED;
      endcase
    end
  end

  always_comb begin
    lights = '0;
    for (int d = 0; d < N_DIR; d++) begin
      if (DIR_W'(d) == cur_dir) begin
        if (state == ST_GREEN)       lights[2*d +: 2] = LAMP_GREEN;
        else if (state == ST_YELLOW) lights[2*d +: 2] = LAMP_YELLOW;
        else                         lights[2*d +: 2] = LAMP_RED;
      end
    end
    walk = (state == ST_PED);
  end

  assign state_o = state;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Scoreboard bench for traffic_light_ctrl at default parameters: expected
// per-cycle observations are queued with stimulus and compared each cycle.
module tb_traffic_light_ctrl;

  logic       clk;
  logic       rstn;
  logic [3:0] req;
  logic       ped_req;
  logic       emerg;
  logic [7:0] lights;
  logic       walk;
  logic [2:0] state_o;
  logic [1:0] cur_dir;

  typedef struct packed {
    logic [2:0] st;
    logic [1:0] dir;
    logic       walk;
    logic [7:0] lights;
  } obs_t;

  localparam logic [2:0] G = 3'd0, Y = 3'd1, AR = 3'd2, P = 3'd3, E = 3'd4;

  obs_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  traffic_light_ctrl dut (
    .clk     (clk),
    .rstn    (rstn),
    .req     (req),
    .ped_req (ped_req),
    .emerg   (emerg),
    .lights  (lights),
    .walk    (walk),
    .state_o (state_o),
    .cur_dir (cur_dir)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic obs_t model(input logic [2:0] st, input logic [1:0] dir);
    obs_t o;
    o.st     = st;
    o.dir    = dir;
    o.walk   = (st == P);
    o.lights = '0;
    if (st == G) o.lights[2*dir +: 2] = 2'b10;
    if (st == Y) o.lights[2*dir +: 2] = 2'b01;
    return o;
  endfunction

  task automatic push(input logic [2:0] st, input logic [1:0] dir, input int n);
    for (int i = 0; i < n; i++) sb_q.push_back(model(st, dir));
  endtask

  // Compare the current observation against the queue head, then advance one cycle.
  task automatic drain(input string name, input int n);
    obs_t act, exp_o;
    for (int i = 0; i < n; i++) begin
      act = '{st: state_o, dir: cur_dir, walk: walk, lights: lights};
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL %s[%0d]: scoreboard empty, got st=%0d dir=%0d", name, i, act.st, act.dir);
      end else begin
        exp_o = sb_q.pop_front();
        if (act !== exp_o) begin
          errors++;
          $display("FAIL %s[%0d]: got st=%0d dir=%0d walk=%0b lights=%b, want st=%0d dir=%0d walk=%0b lights=%b",
                   name, i, act.st, act.dir, act.walk, act.lights,
                   exp_o.st, exp_o.dir, exp_o.walk, exp_o.lights);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    rstn    = 1'b0;
    req     = '0;
    ped_req = 1'b0;
    emerg   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    sb_q.delete();
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if (state_o !== 3'd0 || lights !== 8'b0000_0010 || walk !== 1'b0 || cur_dir !== 2'd0) begin
      errors++;
      $display("FAIL %s: got st=%0d dir=%0d walk=%0b lights=%b, want st=0 dir=0 walk=0 lights=00000010",
               name, state_o, cur_dir, walk, lights);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b1; req = '0; ped_req = 1'b0; emerg = 1'b0;
    #1 rstn = 1'b0;
    #1 check_reset_outputs("reset_initial");
    do_reset();
    emerg = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (state_o !== E) begin
      errors++;
      $display("FAIL emerg_before_reset: got st=%0d, want st=4", state_o);
    end
    #2 rstn = 1'b0;
    #1 check_reset_outputs("reset_in_emerg");
    emerg = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_default_cycle();
    do_reset();
    push(G, 0, 10); push(Y, 0, 2); push(AR, 0, 1); push(G, 1, 1);
    drain("default_cycle", 14);
  endtask

  task automatic test_demand_cut();
    do_reset();
    req = 4'b1000;
    push(G, 0, 4); push(Y, 0, 2); push(AR, 0, 1); push(G, 3, 1);
    drain("demand_cut", 8);
  endtask

  task automatic test_ped();
    do_reset();
    push(G, 0, 4); push(Y, 0, 2); push(AR, 0, 1); push(P, 0, 3);
    push(G, 1, 10); push(Y, 1, 1);
    ped_req = 1'b1;
    drain("ped", 1);
    ped_req = 1'b0;
    drain("ped", 6);
    ped_req = 1'b1;            // pressed during PED: must be ignored
    drain("ped_walk", 1);
    ped_req = 1'b0;
    drain("ped_after", 13);
  endtask

  task automatic test_emerg();
    do_reset();
    push(G, 0, 4); push(Y, 0, 2); push(AR, 0, 1); push(G, 2, 3);
    push(E, 2, 5); push(AR, 2, 1); push(G, 1, 1);
    req = 4'b0100;
    drain("emerg_lead", 7);
    req = 4'b0010;
    drain("emerg_g2", 2);
    emerg = 1'b1;
    drain("emerg_g2", 1);
    drain("emerg_hold", 4);
    emerg = 1'b0;
    drain("emerg_exit", 3);
  endtask

  task automatic test_reset_mid();
    do_reset();
    push(G, 0, 4); push(Y, 0, 2); push(AR, 0, 1); push(G, 1, 4); push(Y, 1, 1);
    req = 4'b0010;
    drain("rstmid_lead", 7);
    req = 4'b0000;
    ped_req = 1'b1;
    drain("rstmid_g1", 1);
    ped_req = 1'b0;
    drain("rstmid_g1", 4);
    #2 rstn = 1'b0;
    #1 check_reset_outputs("reset_in_yellow");
    @(negedge clk);
    rstn = 1'b1;
    sb_q.delete();
    push(G, 0, 10); push(Y, 0, 1);
    drain("rstmid_after", 11);
  endtask

  task automatic test_ped_with_demand();
    do_reset();
    push(G, 0, 4); push(Y, 0, 2); push(AR, 0, 1); push(P, 0, 3); push(G, 2, 1);
    drain("ped_demand", 3);
    ped_req = 1'b1;
    req     = 4'b0100;
    drain("ped_demand", 1);
    ped_req = 1'b0;
    drain("ped_demand", 7);
  endtask

  initial begin
    test_reset();
    test_default_cycle();
    test_demand_cut();
    test_ped();
    test_emerg();
    test_reset_mid();
    test_ped_with_demand();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: got %0d entries, want 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
